// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed access latency and byte-enable writes
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = (ADDR_W - 2 > IW) ? ADDR_W - 2 : IW;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       mem [DEPTH];
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic [AW-1:0]     word;
  logic [IW-1:0]     idx;
  logic              err;
  logic              accept;
  logic              commit;
  assign req_ready = (state == IDLE) & ~RST;
  assign busy      = state != IDLE;
  // With zero latency the commit happens on the acceptance edge, so it must see the live request
  always_comb begin
    c_we    = (state == IDLE) ? req_we    : we_q;
    c_addr  = (state == IDLE) ? req_addr  : addr_q;
    c_wdata = (state == IDLE) ? req_wdata : wdata_q;
    c_be    = (state == IDLE) ? req_be    : be_q;
    word    = AW'(c_addr[ADDR_W-1:2]);
    idx     = word[IW-1:0];
    err     = (|c_addr[1:0]) | ({1'b0, word} >= (AW+1)'(DEPTH));
    accept  = (state == IDLE) & req_valid & ~RST;
    commit  = ~RST & ((accept & (LATENCY == 0)) | ((state == WAIT) & (cnt == 4'd0)));
  end
  always_ff @(posedge CLK) begin
    if (commit & c_we & ~err)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        state   <= (LATENCY == 0) ? RESP : WAIT;
        cnt     <= 4'(LATENCY > 0 ? LATENCY - 1 : 0);
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (commit) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= (c_we | err) ? 32'd0 : mem[idx];
        rsp_err   <= err;
      end
      if ((state == RESP) & rsp_ready) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
